// File: rtl/dmem_ctrl.sv
// dmem_ctrl: parametrised single-port data memory with byte-masked stores and a hardware clear after reset.
// Latency: load data is registered and valid 1 cycle after acceptance; the clear takes DEPTH cycles after reset.
// Backpressure: req_ready is low during the clear and while mem_on is low; responses are never stalled.
// Optional build macro: DMEM_OOR_ERR_EN (pulses rsp_err for out-of-range accesses).
module dmem_ctrl #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int MASK_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_on,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [MASK_W-1:0] req_mask,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              init_done
);

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

   state_t             state;
   state_t             state_next;
   logic [ADDR_W-1:0]  clr_cnt;
   logic [DATA_W-1:0]  mem [DEPTH];

   logic               accept;
   logic               load_acc;
   logic               in_range;

   // Single write port, shared by the clear sequence and stores
   logic               wr_en;
   logic [ADDR_W-1:0]  wr_addr;
   logic [DATA_W-1:0]  wr_data;
   logic [MASK_W-1:0]  wr_mask;

   // Address range check; constant-true when DEPTH fills the address space
   generate
      if (DEPTH == (1 << ADDR_W)) begin : g_full_range
         assign in_range = 1'b1;
      end else begin : g_part_range
         localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
         assign in_range = ({1'b0, req_addr} < DEPTH_X);
      end
   endgenerate

   assign req_ready = (state == READY) && mem_on;
   assign accept    = req_valid && req_ready;
   assign load_acc  = accept && !req_we;
   assign init_done = (state == READY);

   // State register and clear-address counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == CLEAR) begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
         end
      end
   end

   // Next state and write-port steering: clear owns the port until READY
   always_comb begin
      state_next = state;
      wr_en      = 1'b0;
      wr_addr    = req_addr;
      wr_data    = req_wdata;
      wr_mask    = req_mask;
      case (state)
         CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt;
            wr_data = '0;
            wr_mask = '1;
            if (clr_cnt == CLR_LAST) begin
               state_next = READY;
            end
         end
         READY: begin
            // out-of-range stores are dropped so they never alias into the array
            wr_en = accept && req_we && in_range;
         end
         default: begin
            state_next = CLEAR;
         end
      endcase
   end

   // Byte-masked write into the array; no reset so it maps onto a RAM macro
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         for (int i = 0; i < MASK_W; i++) begin
            if (wr_mask[i]) begin
               mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   // Registered read port: data holds between loads, out-of-range loads return zero
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= load_acc;
         if (load_acc) begin
            rsp_rdata <= in_range ? mem[req_addr] : '0;
         end
      end
   end

`ifdef DMEM_OOR_ERR_EN
   // One-cycle error pulse after any accepted out-of-range request
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_err <= 1'b0;
      end else begin
         rsp_err <= accept && !in_range;
      end
   end
`else
   assign rsp_err = 1'b0;
`endif

endmodule
